// File: rtl/jpeg_capture_pkg.sv
// Shared types and helpers for the JPEG capture controller.
// Contents:
//   capState_e - capture sequencer states
//   capMode_e  - capture modes sampled on start
//   BYTE_W     - bits per byte
//   bankWidth  - index width for a bank count (at least one bit)
package jpeg_capture_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_RESET,
    S_WAIT_EOF,
    S_WAIT_SOF,
    S_COMPRESS,
    S_COMMIT
  } capState_e;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'd0,
    MODE_CONTINUOUS = 2'd1,
    MODE_BURST      = 2'd2,
    MODE_RESERVED   = 2'd3
  } capMode_e;

  // A single bank still needs a one-bit index so that ports never collapse to zero width.
  function automatic int bankWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jcap_gearbox.sv
// Narrows encoder beats of IN_BYTES into image-buffer words of OUT_BYTES.
// Ports:
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   en_i             - accept new beats (capture is compressing)
//   flush_i          - drop any pending words
//   in_data_i        - encoder beat, byte 0 in the low bits
//   in_bytes_i       - valid bytes in beat (low bytes)
//   in_tlast_i       - beat is the last of the image
//   in_valid_i       - beat valid
//   in_hold_o        - backpressure to the encoder
//   word_o           - current output word, unused bytes zero
//   word_valid_o     - word_o carries a word this cycle
//   word_last_o      - this is the final word of the image
module jcap_gearbox
  import jpeg_capture_pkg::*;
#(
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [BYTE_W*IN_BYTES-1:0]    in_data_i,
  input  logic [$clog2(IN_BYTES):0]     in_bytes_i,
  input  logic                          in_tlast_i,
  input  logic                          in_valid_i,
  output logic                          in_hold_o,
  output logic [BYTE_W*OUT_BYTES-1:0]   word_o,
  output logic                          word_valid_o,
  output logic                          word_last_o
);

  localparam int WORDS = IN_BYTES / OUT_BYTES;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int IBW   = $clog2(IN_BYTES) + 1;

  logic [BYTE_W*IN_BYTES-1:0] beat_q, beat_d, maskedData;
  logic [WCW-1:0]             left_q, left_d, inWords;
  logic [IBW:0]               roundUp;
  logic                       tlast_q, tlast_d;
  logic                       accept;

  // Bytes beyond in_bytes are zeroed so the padding of the last word is clean.
  always_comb begin
    maskedData = '0;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (IBW'(b) < in_bytes_i) begin
        maskedData[BYTE_W*b +: BYTE_W] = in_data_i[BYTE_W*b +: BYTE_W];
      end
    end
    roundUp = {1'b0, in_bytes_i} + (IBW+1)'(OUT_BYTES - 1);
    inWords = WCW'(roundUp >> $clog2(OUT_BYTES));
  end

  // The final beat of an image is held until all its words leave, so a beat of the
  // next image can never slip in on the cycle the controller moves to commit.
  assign in_hold_o    = en_i && ((left_q > WCW'(1)) || ((left_q != '0) && tlast_q));
  assign accept       = en_i && in_valid_i && !in_hold_o;
  assign word_o       = beat_q[BYTE_W*OUT_BYTES-1:0];
  assign word_valid_o = (left_q != '0);
  assign word_last_o  = (left_q == WCW'(1)) && tlast_q;

  always_comb begin
    beat_d  = beat_q;
    left_d  = left_q;
    tlast_d = tlast_q;
    if (left_q != '0) begin
      beat_d = beat_q >> (BYTE_W * OUT_BYTES);
      left_d = left_q - WCW'(1);
    end
    if (accept) begin
      beat_d  = maskedData;
      left_d  = inWords;
      tlast_d = in_tlast_i;
    end
    if (flush_i) begin
      left_d  = '0;
      tlast_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q  <= '0;
      left_q  <= '0;
      tlast_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      left_q  <= left_d;
      tlast_q <= tlast_d;
    end
  end

endmodule

// File: rtl/jpeg_capture_ctrl.sv
// Capture sequencer and output stage between the JPEG encoder and the image buffer.
// Arms the encoder once per frame, narrows encoder beats into addressed buffer words and
// rotates through NUM_BANKS image banks, reporting overflow and frame-wait timeouts.
// Ports:
//   pixel_clock_in / pixel_reset_in          - clock, asynchronous active-high reset
//   start_capture_in / stop_capture_in       - start pulse, abort pulse (abort wins)
//   mode_in, burst_count_in                  - capture mode and burst length, sampled on start
//   bank_release_in                          - per-bank pulse: consumer done with bank
//   frame_valid_in                           - sensor frame valid
//   jpeg_reset_n_out, jpeg_en_out            - encoder reset and sensor gate
//   in_data/in_bytes/in_tlast/in_valid/in_hold - encoder stream with backpressure
//   data_out/address_out/bank_out/data_valid_out - image-buffer write port
//   image_valid_out/image_size_out/image_bank_out - committed image report
//   overflow_out, timeout_out, busy_out      - status
module jpeg_capture_ctrl
  import jpeg_capture_pkg::*;
#(
  parameter int IN_BYTES     = 16,
  parameter int OUT_BYTES    = 4,
  parameter int NUM_BANKS    = 2,
  parameter int BANK_BYTES   = 65536,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 2**22
) (
  input  logic                               pixel_clock_in,
  input  logic                               pixel_reset_in,
  input  logic                               start_capture_in,
  input  logic                               stop_capture_in,
  input  logic [1:0]                         mode_in,
  input  logic [7:0]                         burst_count_in,
  input  logic [NUM_BANKS-1:0]               bank_release_in,
  input  logic                               frame_valid_in,
  output logic                               jpeg_reset_n_out,
  output logic                               jpeg_en_out,
  input  logic [BYTE_W*IN_BYTES-1:0]         in_data,
  input  logic [$clog2(IN_BYTES):0]          in_bytes,
  input  logic                               in_tlast,
  input  logic                               in_valid,
  output logic                               in_hold,
  output logic [BYTE_W*OUT_BYTES-1:0]        data_out,
  output logic [$clog2(BANK_BYTES)-1:0]      address_out,
  output logic [bankWidth(NUM_BANKS)-1:0]    bank_out,
  output logic                               data_valid_out,
  output logic                               image_valid_out,
  output logic [$clog2(BANK_BYTES):0]        image_size_out,
  output logic [bankWidth(NUM_BANKS)-1:0]    image_bank_out,
  output logic                               overflow_out,
  output logic                               timeout_out,
  output logic                               busy_out
);

  localparam int AW = $clog2(BANK_BYTES);
  localparam int BW = bankWidth(NUM_BANKS);
  localparam int TW = $clog2(TIMEOUT + RESET_CYCLES + 1);

  capState_e            state_q, state_d;
  capMode_e             mode_q, mode_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7:0]           framesLeft_q, framesLeft_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [BW-1:0]        ptr_q, ptr_d, curBank_q, curBank_d;
  logic [AW:0]          addr_q, addr_d, size_q, size_d, imgSize_q, imgSize_d;
  logic [BW-1:0]        imgBank_q, imgBank_d;
  logic                 imgOvf_q, imgOvf_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic                 stopPulse_q, stopPulse_d, imgValid_q, imgValid_d;

  logic                 gbEn, beatAccept, wordValid, wordLast;
  logic                 freeFound;
  logic [BW-1:0]        freeBank;
  logic [BW:0]          idxW;

  assign gbEn       = (state_q == S_COMPRESS) && !stop_capture_in;
  assign beatAccept = gbEn && in_valid && !in_hold;

  jcap_gearbox #(
    .IN_BYTES  (IN_BYTES),
    .OUT_BYTES (OUT_BYTES)
  ) u_gearbox (
    .clk_i        (pixel_clock_in),
    .rst_i        (pixel_reset_in),
    .en_i         (gbEn),
    .flush_i      (stop_capture_in),
    .in_data_i    (in_data),
    .in_bytes_i   (in_bytes),
    .in_tlast_i   (in_tlast),
    .in_valid_i   (in_valid),
    .in_hold_o    (in_hold),
    .word_o       (data_out),
    .word_valid_o (wordValid),
    .word_last_o  (wordLast)
  );

  // Round-robin search: scanning offsets high to low lets the smallest offset from the
  // pointer win, i.e. the lowest free bank at or after the pointer.
  always_comb begin
    freeFound = 1'b0;
    freeBank  = '0;
    idxW      = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      idxW = {1'b0, ptr_q} + (BW+1)'(i);
      if (idxW >= (BW+1)'(NUM_BANKS)) idxW = idxW - (BW+1)'(NUM_BANKS);
      if (!full_q[idxW[BW-1:0]]) begin
        freeFound = 1'b1;
        freeBank  = idxW[BW-1:0];
      end
    end
  end

  // Sequencer next state; an abort at the end overrides everything including a commit.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    timer_d      = timer_q;
    framesLeft_d = framesLeft_q;
    full_d       = full_q & ~bank_release_in;
    ptr_d        = ptr_q;
    curBank_d    = curBank_q;
    addr_d       = addr_q;
    size_d       = size_q;
    imgSize_d    = imgSize_q;
    imgBank_d    = imgBank_q;
    imgOvf_d     = imgOvf_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    stopPulse_d  = 1'b0;
    imgValid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_capture_in) begin
          mode_d       = (mode_in == 2'd3) ? MODE_SINGLE : capMode_e'(mode_in);
          framesLeft_d = (mode_in != 2'd2) ? 8'd1 :
                         (burst_count_in == 8'd0) ? 8'd1 : burst_count_in;
          ovf_d        = 1'b0;
          tmo_d        = 1'b0;
          state_d      = S_WAIT_BANK;
        end
      end
      S_WAIT_BANK: begin
        if (freeFound) begin
          curBank_d = freeBank;
          timer_d   = '0;
          state_d   = S_RESET;
        end
      end
      S_RESET: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(RESET_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_WAIT_EOF;
        end
      end
      S_WAIT_EOF, S_WAIT_SOF: begin
        timer_d = timer_q + TW'(1);
        if ((state_q == S_WAIT_EOF) && !frame_valid_in) begin
          timer_d = '0;
          state_d = S_WAIT_SOF;
        end else if ((state_q == S_WAIT_SOF) && frame_valid_in) begin
          addr_d   = '0;
          size_d   = '0;
          imgOvf_d = 1'b0;
          state_d  = S_COMPRESS;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COMPRESS: begin
        if (beatAccept) size_d = size_q + (AW+1)'(in_bytes);
        // Address bit AW set means the word falls past the bank; it is swallowed.
        if (wordValid) begin
          if (addr_q[AW]) begin
            ovf_d    = 1'b1;
            imgOvf_d = 1'b1;
          end else begin
            addr_d = addr_q + (AW+1)'(OUT_BYTES);
          end
          if (wordLast) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!imgOvf_q) begin
          imgValid_d        = 1'b1;
          imgSize_d         = size_q;
          imgBank_d         = curBank_q;
          full_d[curBank_q] = 1'b1;
          ptr_d = (curBank_q == BW'(NUM_BANKS - 1)) ? '0 : curBank_q + BW'(1);
        end
        if (mode_q == MODE_CONTINUOUS) begin
          state_d = S_WAIT_BANK;
        end else if (framesLeft_q <= 8'd1) begin
          state_d = S_IDLE;
        end else begin
          framesLeft_d = framesLeft_q - 8'd1;
          state_d      = S_WAIT_BANK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_capture_in) begin
      state_d     = S_IDLE;
      stopPulse_d = 1'b1;
      imgValid_d  = 1'b0;
      imgSize_d   = imgSize_q;
      imgBank_d   = imgBank_q;
      full_d      = full_q & ~bank_release_in;
      ptr_d       = ptr_q;
    end
  end

  always_ff @(posedge pixel_clock_in or posedge pixel_reset_in) begin
    if (pixel_reset_in) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_SINGLE;
      timer_q      <= '0;
      framesLeft_q <= '0;
      full_q       <= '0;
      ptr_q        <= '0;
      curBank_q    <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      imgSize_q    <= '0;
      imgBank_q    <= '0;
      imgOvf_q     <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      stopPulse_q  <= 1'b0;
      imgValid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      timer_q      <= timer_d;
      framesLeft_q <= framesLeft_d;
      full_q       <= full_d;
      ptr_q        <= ptr_d;
      curBank_q    <= curBank_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      imgSize_q    <= imgSize_d;
      imgBank_q    <= imgBank_d;
      imgOvf_q     <= imgOvf_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      stopPulse_q  <= stopPulse_d;
      imgValid_q   <= imgValid_d;
    end
  end

  assign jpeg_reset_n_out = !((state_q == S_RESET) || stopPulse_q);
  assign jpeg_en_out      = (state_q == S_WAIT_SOF) || (state_q == S_COMPRESS);
  assign busy_out         = (state_q != S_IDLE);
  assign data_valid_out   = (state_q == S_COMPRESS) && wordValid && !addr_q[AW];
  assign address_out      = addr_q[AW-1:0];
  assign bank_out         = curBank_q;
  assign image_valid_out  = imgValid_q;
  assign image_size_out   = imgSize_q;
  assign image_bank_out   = imgBank_q;
  assign overflow_out     = ovf_q;
  assign timeout_out      = tmo_q;

endmodule
